// File: rtl/freq_reporter_if.sv
// Measurement-in / transmitter-out signal bundle for freq_reporter.
// master: the environment (measurement source and word transmitter).
// slave:  the reporter itself.
interface freq_reporter_if;
   logic        meas_valid;
   logic [31:0] meas_count;
   logic        tx_busy;
   logic        tx_start;
   logic [31:0] tx_word;
   logic [2:0]  tx_bytes;
   logic        sending;
   logic        overrun;
   logic        timeout_err;

   modport master (
      output meas_valid,
      output meas_count,
      output tx_busy,
      input  tx_start,
      input  tx_word,
      input  tx_bytes,
      input  sending,
      input  overrun,
      input  timeout_err
   );

   modport slave (
      input  meas_valid,
      input  meas_count,
      input  tx_busy,
      output tx_start,
      output tx_word,
      output tx_bytes,
      output sending,
      output overrun,
      output timeout_err
   );
endinterface

// File: rtl/freq_reporter.sv
// Frequency reporter: buffers one measurement and ships it to a word transmitter
// as a three-segment frame (sync word, 32-bit count, one-byte checksum).
module freq_reporter #(
   parameter logic [15:0] SYNC_WORD = 16'h55AA,
   parameter int unsigned TIMEOUT   = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   freq_reporter_if.slave  bus_io
);

   typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;
   typedef enum logic [1:0] {SegSync, SegData, SegCsum} seg_e;

   // Last counter value before the wait for tx_busy is abandoned.
   localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);

   state_e      state_q;
   seg_e        seg_q;
   logic [31:0] act_count_q;
   logic [7:0]  csum_q;
   logic [3:0]  cnt_q;
   logic        tx_start_q;
   logic [31:0] tx_word_q;
   logic [2:0]  tx_bytes_q;
   logic        timeout_err_q;

   logic [31:0] pend_count_q;
   logic        pend_valid_q;
   logic        overrun_q;

   logic        consume;
   logic [7:0]  pend_sum;

   // The idle engine takes the pending value in the same cycle it sees it.
   assign consume  = (state_q == StIdle) && pend_valid_q;
   assign pend_sum = pend_count_q[7:0] + pend_count_q[15:8]
                   + pend_count_q[23:16] + pend_count_q[31:24];

   // One-deep pending buffer; a new value wins over an unconsumed one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_count_q <= '0;
         pend_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         overrun_q <= bus_io.meas_valid && pend_valid_q && !consume;
         if (bus_io.meas_valid) begin
            pend_count_q <= bus_io.meas_count;
            pend_valid_q <= 1'b1;
         end else if (consume) begin
            pend_valid_q <= 1'b0;
         end
      end
   end

   // Frame engine: issue each segment, wait for the transmitter to take it and finish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         seg_q         <= SegSync;
         act_count_q   <= '0;
         csum_q        <= '0;
         cnt_q         <= '0;
         tx_start_q    <= 1'b0;
         tx_word_q     <= '0;
         tx_bytes_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pend_valid_q) begin
                  act_count_q <= pend_count_q;
                  csum_q      <= 8'h00 - pend_sum;
                  seg_q       <= SegSync;
                  tx_word_q   <= {16'h0000, SYNC_WORD};
                  tx_bytes_q  <= 3'd2;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               if (!bus_io.tx_busy) begin
                  tx_start_q <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= StWaitBusy;
               end
            end
            StWaitBusy: begin
               if (bus_io.tx_busy) begin
                  state_q <= StWaitDone;
               end else if (cnt_q == TimeoutLast) begin
                  // Transmitter never acknowledged: drop the whole frame.
                  timeout_err_q <= 1'b1;
                  state_q       <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            StWaitDone: begin
               if (!bus_io.tx_busy) begin
                  unique case (seg_q)
                     SegSync: begin
                        seg_q      <= SegData;
                        tx_word_q  <= act_count_q;
                        tx_bytes_q <= 3'd4;
                        state_q    <= StIssue;
                     end
                     SegData: begin
                        seg_q      <= SegCsum;
                        tx_word_q  <= {24'h000000, csum_q};
                        tx_bytes_q <= 3'd1;
                        state_q    <= StIssue;
                     end
                     default: state_q <= StIdle;
                  endcase
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.tx_start    = tx_start_q;
   assign bus_io.tx_word     = tx_word_q;
   assign bus_io.tx_bytes    = tx_bytes_q;
   assign bus_io.sending     = (state_q != StIdle);
   assign bus_io.overrun     = overrun_q;
   assign bus_io.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_freq_reporter.sv
// Self-checking bench for freq_reporter: table of single frames, hand-written
// corner sequences, and randomized measurements against a frame-level model.
module tb_freq_reporter;

   logic clk;
   logic rst_n;

   freq_reporter_if bus ();

   freq_reporter #(
      .SYNC_WORD (16'h55AA),
      .TIMEOUT   (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] word;
      logic [2:0]  bytes;
   } seg_t;

   typedef struct {
      logic [31:0] count;
      logic [7:0]  csum;
      int          busy;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: everything the DUT hands to the transmitter, plus pulse counts.
   seg_t seg_q[$];
   int   start_cyc_q[$];
   int   n_starts = 0;
   int   n_ovr = 0;
   int   n_to = 0;
   int   n_dbl = 0;
   int   last_start_cyc = 0;
   int   last_to_cyc = 0;
   logic prev_start = 1'b0;

   always @(negedge clk) begin
      if (bus.tx_start === 1'b1) begin
         seg_q.push_back({bus.tx_word, bus.tx_bytes});
         start_cyc_q.push_back(cyc);
         n_starts++;
         last_start_cyc = cyc;
         if (prev_start) n_dbl++;
      end
      prev_start = (bus.tx_start === 1'b1);
      if (bus.overrun === 1'b1) n_ovr++;
      if (bus.timeout_err === 1'b1) begin
         n_to++;
         last_to_cyc = cyc;
      end
   end

   // Transmitter model: 0 = busy for busy_len cycles per start, 1 = busy stuck low,
   // 2 = busy stuck high.
   int xmode    = 0;
   int busy_len = 20;
   int left     = 0;

   always @(negedge clk) begin
      case (xmode)
         1: begin bus.tx_busy = 1'b0; left = 0; end
         2: begin bus.tx_busy = 1'b1; left = 0; end
         default: begin
            if (bus.tx_start === 1'b1) begin
               bus.tx_busy = 1'b1;
               left = busy_len;
            end else if (left > 0) begin
               left--;
               if (left == 0) bus.tx_busy = 1'b0;
            end else begin
               bus.tx_busy = 1'b0;
            end
         end
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_meas(input logic [31:0] c, output int mcyc);
      @(negedge clk);
      bus.meas_valid = 1'b1;
      bus.meas_count = c;
      mcyc = cyc;
      @(negedge clk);
      bus.meas_valid = 1'b0;
   endtask

   // Done when sending has stayed low for several cycles (frames may be back to back).
   task automatic wait_idle(input int budget);
      int quiet = 0;
      int b = 0;
      while (quiet < 4 && b < budget) begin
         @(negedge clk);
         b++;
         if (bus.sending === 1'b1) quiet = 0;
         else quiet++;
      end
      check("engine_idle", 64'(quiet >= 4), 64'd1);
   endtask

   // Reference frame: sync, raw count, and the byte that makes the data bytes sum to 0.
   function automatic seg_t exp_seg(input logic [31:0] c, input int j);
      seg_t r;
      int   s;
      int   cs;
      s  = int'(c[7:0]) + int'(c[15:8]) + int'(c[23:16]) + int'(c[31:24]);
      cs = (256 - (s % 256)) % 256;
      case (j)
         0:       begin r.word = 32'h0000_55AA; r.bytes = 3'd2; end
         1:       begin r.word = c;             r.bytes = 3'd4; end
         default: begin r.word = 32'(cs);       r.bytes = 3'd1; end
      endcase
      return r;
   endfunction

   function automatic seg_t get_seg(input int idx);
      if (idx < seg_q.size()) return seg_q[idx];
      return '0;
   endfunction

   logic [31:0] exp_q[$];

   task automatic check_frames(input int base, input string tag);
      check({tag, "_nseg"}, 64'(seg_q.size() - base), 64'(3 * exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         for (int j = 0; j < 3; j++) begin
            check($sformatf("%s_f%0d_s%0d", tag, i, j), 64'(get_seg(base + 3 * i + j)),
                  64'(exp_seg(exp_q[i], j)));
         end
      end
      exp_q.delete();
   endtask

   vec_t        tbl[5];
   int          mc;
   int          base;
   int          s0;
   int          o0;
   int          t0;
   int          bound;
   logic [31:0] rc;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.meas_valid = 1'b0;
      bus.meas_count = '0;
      rst_n = 1'b0;
      tbl[0] = '{32'h0102_0304, 8'hF6, 20};
      tbl[1] = '{32'hFFFF_FFFF, 8'h04, 5};
      tbl[2] = '{32'h1234_5678, 8'hEC, 2};
      tbl[3] = '{32'h8080_8080, 8'h00, 1};
      tbl[4] = '{32'h0000_00FF, 8'h01, 4};

      tick(3);
      check("rst_tx_start",    64'(bus.tx_start),    64'd0);
      check("rst_tx_word",     64'(bus.tx_word),     64'd0);
      check("rst_tx_bytes",    64'(bus.tx_bytes),    64'd0);
      check("rst_sending",     64'(bus.sending),     64'd0);
      check("rst_overrun",     64'(bus.overrun),     64'd0);
      check("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
      rst_n = 1'b1;
      tick(3);

      // Single frames from the table.
      for (int i = 0; i < 5; i++) begin
         busy_len = tbl[i].busy;
         base = seg_q.size();
         send_meas(tbl[i].count, mc);
         wait_idle(500);
         check($sformatf("tbl%0d_nseg", i), 64'(seg_q.size() - base), 64'd3);
         check($sformatf("tbl%0d_sync", i), 64'(get_seg(base)),     {29'd0, 32'h0000_55AA, 3'd2});
         check($sformatf("tbl%0d_data", i), 64'(get_seg(base + 1)), {29'd0, tbl[i].count, 3'd4});
         check($sformatf("tbl%0d_csum", i), 64'(get_seg(base + 2)),
               {29'd0, 24'd0, tbl[i].csum, 3'd1});
         check($sformatf("tbl%0d_sending", i), 64'(bus.sending), 64'd0);
         if (i == 0) begin
            check("latency", 64'((base < start_cyc_q.size()) ? start_cyc_q[base] - mc : -1),
                  64'd3);
         end
      end

      // Second measurement during the first frame: two frames, no overrun.
      busy_len = 6;
      base = seg_q.size();
      o0 = n_ovr;
      send_meas(32'h1111_1111, mc);
      tick(8);
      send_meas(32'h2222_2222, mc);
      wait_idle(800);
      exp_q.push_back(32'h1111_1111);
      exp_q.push_back(32'h2222_2222);
      check_frames(base, "b2b");
      check("b2b_overrun", 64'(n_ovr - o0), 64'd0);

      // A, B, C in one frame: C overwrites B.
      base = seg_q.size();
      o0 = n_ovr;
      send_meas(32'hA0A0_0001, mc);
      tick(4);
      send_meas(32'hB0B0_0002, mc);
      tick(2);
      send_meas(32'hC0C0_0003, mc);
      wait_idle(800);
      exp_q.push_back(32'hA0A0_0001);
      exp_q.push_back(32'hC0C0_0003);
      check_frames(base, "ovr");
      check("ovr_pulses", 64'(n_ovr - o0), 64'd1);

      // Transmitter never goes busy: one start, timeout 8 cycles later, then quiet.
      xmode = 1;
      base = seg_q.size();
      s0 = n_starts;
      t0 = n_to;
      send_meas(32'hDEAD_BEEF, mc);
      tick(40);
      check("to_starts", 64'(n_starts - s0), 64'd1);
      check("to_pulses", 64'(n_to - t0), 64'd1);
      check("to_delay", 64'(last_to_cyc - last_start_cyc), 64'd8);
      check("to_sending", 64'(bus.sending), 64'd0);
      check("to_seg", 64'(get_seg(base)), 64'(exp_seg(32'hDEAD_BEEF, 0)));

      // Pending value survives an abort and restarts from SYNC.
      base = seg_q.size();
      s0 = n_starts;
      t0 = n_to;
      send_meas(32'h0000_0001, mc);
      tick(3);
      send_meas(32'h0000_0002, mc);
      tick(60);
      check("to2_starts", 64'(n_starts - s0), 64'd2);
      check("to2_pulses", 64'(n_to - t0), 64'd2);
      check("to2_seg0", 64'(get_seg(base)),     64'(exp_seg(32'h0000_0001, 0)));
      check("to2_seg1", 64'(get_seg(base + 1)), 64'(exp_seg(32'h0000_0002, 0)));
      xmode = 0;
      tick(2);

      // Zero count, busy already high at ISSUE: start withheld until busy drops.
      xmode = 2;
      base = seg_q.size();
      s0 = n_starts;
      send_meas(32'h0, mc);
      tick(10);
      check("zero_held_starts", 64'(n_starts - s0), 64'd0);
      check("zero_held_sending", 64'(bus.sending), 64'd1);
      busy_len = 3;
      xmode = 0;
      wait_idle(500);
      check("zero_csum", 64'(get_seg(base + 2)), {29'd0, 32'h0, 3'd1});
      exp_q.push_back(32'h0);
      check_frames(base, "zero");

      // Reset during the DATA segment.
      busy_len = 10;
      base = seg_q.size();
      send_meas(32'h5A5A_A5A5, mc);
      bound = 0;
      while (seg_q.size() < base + 2 && bound < 300) begin
         @(negedge clk);
         bound++;
      end
      check("mid_reached_data", 64'(seg_q.size() - base), 64'd2);
      tick(3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx_start",    64'(bus.tx_start),    64'd0);
      check("mid_rst_tx_word",     64'(bus.tx_word),     64'd0);
      check("mid_rst_tx_bytes",    64'(bus.tx_bytes),    64'd0);
      check("mid_rst_sending",     64'(bus.sending),     64'd0);
      check("mid_rst_overrun",     64'(bus.overrun),     64'd0);
      check("mid_rst_timeout_err", 64'(bus.timeout_err), 64'd0);
      tick(3);
      rst_n = 1'b1;
      s0 = n_starts;
      tick(50);
      check("mid_no_start", 64'(n_starts - s0), 64'd0);
      base = seg_q.size();
      send_meas(32'h0BAD_F00D, mc);
      wait_idle(500);
      exp_q.push_back(32'h0BAD_F00D);
      check_frames(base, "post_rst");

      // Randomized counts, busy lengths and optional second measurement.
      for (int i = 0; i < 20; i++) begin
         busy_len = $urandom_range(1, 6);
         base = seg_q.size();
         o0 = n_ovr;
         rc = $urandom;
         exp_q.push_back(rc);
         send_meas(rc, mc);
         if ($urandom_range(0, 2) == 0) begin
            tick($urandom_range(1, 30));
            rc = $urandom;
            exp_q.push_back(rc);
            send_meas(rc, mc);
         end
         wait_idle(1000);
         check_frames(base, $sformatf("rnd%0d", i));
         check($sformatf("rnd%0d_overrun", i), 64'(n_ovr - o0), 64'd0);
      end

      check("tx_start_one_cycle", 64'(n_dbl), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
